serial_sub: RTL and testbench

Parametrised bit-serial subtractor: computes D = A − B − BIN over WIDTH clock cycles, LSB first, with one full-subtractor cell and a registered borrow. Sits beside the combinational subtractor cells in the arithmetic library and serves area-constrained datapaths that can tolerate multi-cycle latency. A start/done handshake sequences operations, and the block reports unsigned borrow-out and signed overflow.

---
 rtl/serial_sub_pkg.sv | 11 +
 rtl/full_sub.sv | 14 +
 rtl/serial_sub.sv | 107 ++++++++++
 tb/tb_serial_sub.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings for the bit-serial arithmetic blocks.
// Encodings are fixed so other sequential arithmetic cells can reuse them.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor cell: D = A - B - Bi with borrow-out Bo.
// Purely combinational; no latency, no flow control.
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor D = A - B - BIN, LSB first, WIDTH cycles per result.
// START is taken only in IDLE/DONE; START during RUN is dropped (no queueing).
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             d_bit;
  logic             br_next;

  full_sub u_cell (
    .A  (a_sr[0]),
    .B  (b_sr[0]),
    .Bi (br_q),
    .D  (d_bit),
    .Bo (br_next)
  );

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        // Back-to-back accept keeps throughput at one result per WIDTH+1 cycles.
        if (START) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      D       <= '0;
      BO      <= 1'b0;
      OVF     <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      BUSY    <= (state_d == S_RUN);
      DONE    <= (state_d == S_DONE);
      if (accept) begin
        a_sr  <= A;
        b_sr  <= B;
        br_q  <= BIN;
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        D     <= {d_bit, D[WIDTH-1:1]};
        br_q  <= br_next;
        cnt_q <= cnt_q + 1'b1;
        // Overflow: borrow into the MSB differs from borrow out of it.
        if (last) begin
          BO  <= br_next;
          OVF <= br_q ^ br_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised checks of serial_sub at WIDTH = 2, 8 and 33.
// Expected results are queued at START and consumed at each DONE pulse.
module tb_serial_sub;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        bin_in;
  logic [32:0] a_in;
  logic [32:0] b_in;
  logic        start2, start8, start33;
  logic        busy2, busy8, busy33;
  logic        done2, done8, done33;
  logic        bo2, bo8, bo33;
  logic        ovf2, ovf8, ovf33;
  logic [1:0]  d2;
  logic [7:0]  d8;
  logic [32:0] d33;
  logic        p2 = 1'b0, p8 = 1'b0, p33 = 1'b0;

  exp_t q2[$];
  exp_t q8[$];
  exp_t q33[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(2)) u2 (
    .CLK(clk), .RST(rst), .START(start2), .A(a_in[1:0]), .B(b_in[1:0]), .BIN(bin_in),
    .BUSY(busy2), .DONE(done2), .D(d2), .BO(bo2), .OVF(ovf2)
  );
  serial_sub #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .START(start8), .A(a_in[7:0]), .B(b_in[7:0]), .BIN(bin_in),
    .BUSY(busy8), .DONE(done8), .D(d8), .BO(bo8), .OVF(ovf8)
  );
  serial_sub #(.WIDTH(33)) u33 (
    .CLK(clk), .RST(rst), .START(start33), .A(a_in), .B(b_in), .BIN(bin_in),
    .BUSY(busy33), .DONE(done33), .D(d33), .BO(bo33), .OVF(ovf33)
  );

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input logic bo, input logic ovf);
    exp_t e;
    e.d = d; e.bo = bo; e.ovf = ovf;
    return e;
  endfunction

  // Reference: unsigned wrap for D, unsigned compare for BO, signed range test for OVF.
  function automatic exp_t ref_sub(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic bin);
    exp_t e;
    logic signed [65:0] sa, sb, t, hi, lo;
    e.d  = (a - b - 64'(bin)) & mask(w);
    e.bo = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
    sa = $signed({2'b00, a});
    if (a[w-1]) sa = sa - (66'sd1 <<< w);
    sb = $signed({2'b00, b});
    if (b[w-1]) sb = sb - (66'sd1 <<< w);
    t  = sa - sb - $signed({65'd0, bin});
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -(66'sd1 <<< (w - 1));
    e.ovf = (t > hi) || (t < lo);
    return e;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 2) ? done2 : (w == 8) ? done8 : done33;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : (w == 8) ? busy8 : busy33;
  endfunction

  task automatic drive_start(input int w, input logic v);
    case (w)
      2:       start2 = v;
      8:       start8 = v;
      default: start33 = v;
    endcase
  endtask

  task automatic push_exp(input int w, input exp_t e);
    case (w)
      2:       q2.push_back(e);
      8:       q8.push_back(e);
      default: q33.push_back(e);
    endcase
  endtask

  task automatic check_done(input int w, input logic [63:0] d, input logic bo, input logic ovf,
                            input logic prev);
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    case (w)
      2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      8:       if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
      default: if (q33.size() > 0) begin e = q33.pop_front(); have = 1'b1; end
    endcase
    tests++;
    assert (have === 1'b1) else begin
      fails++; $error("FAIL unexpected_done_w%0d observed=DONE expected=no DONE", w);
    end
    if (have) begin
      tests++;
      assert (d === e.d) else begin
        fails++; $error("FAIL d_w%0d observed=%0h expected=%0h", w, d, e.d);
      end
      tests++;
      assert (bo === e.bo) else begin
        fails++; $error("FAIL bo_w%0d observed=%0b expected=%0b", w, bo, e.bo);
      end
      tests++;
      assert (ovf === e.ovf) else begin
        fails++; $error("FAIL ovf_w%0d observed=%0b expected=%0b", w, ovf, e.ovf);
      end
    end
    tests++;
    assert (prev === 1'b0) else begin
      fails++; $error("FAIL done_width_w%0d observed=2+ cycles expected=1 cycle", w);
    end
  endtask

  always @(negedge clk) begin
    if (done2)  check_done(2, 64'(d2), bo2, ovf2, p2);
    if (done8)  check_done(8, 64'(d8), bo8, ovf8, p8);
    if (done33) check_done(33, 64'(d33), bo33, ovf33, p33);
    p2  <= done2;
    p8  <= done8;
    p33 <= done33;
  end

  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic bin, input exp_t e);
    int cyc;
    @(negedge clk);
    a_in = a[32:0]; b_in = b[32:0]; bin_in = bin;
    drive_start(w, 1'b1);
    push_exp(w, e);
    @(negedge clk);
    drive_start(w, 1'b0);
    tests++;
    assert (busy_of(w) === 1'b1) else begin
      fails++; $error("FAIL busy_w%0d observed=%0b expected=1", w, busy_of(w));
    end
    cyc = 0;
    while (done_of(w) !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    assert (cyc === w) else begin
      fails++; $error("FAIL latency_w%0d observed=%0d expected=%0d", w, cyc, w);
    end
  endtask

  initial begin
    int cyc;
    int ws[3];
    logic [63:0] ra, rb;
    logic rbin;
    ws = '{2, 8, 33};
    rst = 1'b1; start2 = 1'b0; start8 = 1'b0; start33 = 1'b0;
    a_in = '0; b_in = '0; bin_in = 1'b0;
    repeat (3) @(negedge clk);

    tests++; assert (busy8 === 1'b0) else begin fails++; $error("FAIL rst_busy observed=%0b expected=0", busy8); end
    tests++; assert (done8 === 1'b0) else begin fails++; $error("FAIL rst_done observed=%0b expected=0", done8); end
    tests++; assert (d8 === 8'h00) else begin fails++; $error("FAIL rst_d observed=%0h expected=0", d8); end
    tests++; assert (bo8 === 1'b0) else begin fails++; $error("FAIL rst_bo observed=%0b expected=0", bo8); end
    tests++; assert (ovf8 === 1'b0) else begin fails++; $error("FAIL rst_ovf observed=%0b expected=0", ovf8); end
    rst = 1'b0;

    run_op(8, 64'h05, 64'h03, 1'b0, mk(64'h02, 1'b0, 1'b0));
    run_op(8, 64'h03, 64'h05, 1'b0, mk(64'hFE, 1'b1, 1'b0));
    run_op(8, 64'h00, 64'h00, 1'b1, mk(64'hFF, 1'b1, 1'b0));
    run_op(8, 64'h80, 64'h01, 1'b0, mk(64'h7F, 1'b0, 1'b1));
    run_op(8, 64'h7F, 64'hFF, 1'b0, mk(64'h80, 1'b1, 1'b1));

    // START re-pulsed on the third RUN edge must be ignored.
    @(negedge clk);
    a_in = 33'h05; b_in = 33'h03; bin_in = 1'b0; start8 = 1'b1;
    q8.push_back(mk(64'h02, 1'b0, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 200) begin
      if (cyc == 2) begin
        start8 = 1'b1; a_in = 33'hAA; b_in = 33'h11; bin_in = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    tests++; assert (cyc === 8) else begin fails++; $error("FAIL ignored_start_latency observed=%0d expected=8", cyc); end

    // START held through DONE: second result 9 cycles after the first.
    @(negedge clk);
    a_in = 33'h80; b_in = 33'h01; bin_in = 1'b0; start8 = 1'b1;
    q8.push_back(mk(64'h7F, 1'b0, 1'b1));
    @(negedge clk);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++; assert (cyc === 8) else begin fails++; $error("FAIL b2b_first_latency observed=%0d expected=8", cyc); end
    a_in = 33'h7F; b_in = 33'hFF;
    q8.push_back(mk(64'h80, 1'b1, 1'b1));
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    tests++; assert (cyc === 9) else begin fails++; $error("FAIL b2b_gap observed=%0d expected=9", cyc); end

    // Reset on the fourth RUN edge discards the operation.
    @(negedge clk);
    a_in = 33'h7F; b_in = 33'h01; bin_in = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    tests++; assert (bo8 === 1'b1) else begin fails++; $error("FAIL bo_hold_in_run observed=%0b expected=1", bo8); end
    tests++; assert (ovf8 === 1'b1) else begin fails++; $error("FAIL ovf_hold_in_run observed=%0b expected=1", ovf8); end
    rst = 1'b1;
    @(negedge clk);
    tests++; assert (busy8 === 1'b0) else begin fails++; $error("FAIL midrst_busy observed=%0b expected=0", busy8); end
    tests++; assert (d8 === 8'h00) else begin fails++; $error("FAIL midrst_d observed=%0h expected=0", d8); end
    tests++; assert (bo8 === 1'b0) else begin fails++; $error("FAIL midrst_bo observed=%0b expected=0", bo8); end
    tests++; assert (ovf8 === 1'b0) else begin fails++; $error("FAIL midrst_ovf observed=%0b expected=0", ovf8); end
    tests++; assert (done8 === 1'b0) else begin fails++; $error("FAIL midrst_done observed=%0b expected=0", done8); end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8, 64'h10, 64'h01, 1'b1, mk(64'h0E, 1'b0, 1'b0));

    // Randomised sweep with boundary operands first.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 30; i++) begin
        ra   = {$urandom, $urandom} & mask(ws[k]);
        rb   = {$urandom, $urandom} & mask(ws[k]);
        rbin = 1'($urandom_range(0, 1));
        if (i == 0) begin ra = 64'd0; rb = mask(ws[k]); rbin = 1'b1; end
        if (i == 1) begin ra = mask(ws[k]); rb = 64'd0; rbin = 1'b0; end
        if (i == 2) begin ra = 64'd1 << (ws[k] - 1); rb = 64'd0; rbin = 1'b1; end
        run_op(ws[k], ra, rb, rbin, ref_sub(ws[k], ra, rb, rbin));
      end
    end

    repeat (5) @(negedge clk);
    tests++;
    assert ((q2.size() + q8.size() + q33.size()) === 0) else begin
      fails++; $error("FAIL pending_results observed=%0d expected=0", q2.size() + q8.size() + q33.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
